// File: rtl/cdr_frame_sync.sv
// -----------------------------------------------------------------------------
// cdr_frame_sync
//
// Byte/frame aligner behind a clock-data-recovery front end. Recovered bits
// arrive one per bit_valid pulse, MSB first. The aligner searches the bit
// stream for SYNC_WORD with a one-bit sliding window. After a match it treats
// the stream as frames of FRAME_BYTES payload bytes, each followed by a sync
// byte. Payload bytes go into a 2-entry first-word-fall-through FIFO. A bad
// sync byte is tolerated until MISS_LIMIT consecutive misses (flywheel).
// After that, lock is dropped and the search starts again.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   ena          block enable; bit_valid is ignored while low
//   clear        synchronous flush of aligner state, FIFO and overflow
//   bit_valid    one-cycle strobe per recovered bit
//   bit_in       recovered bit, qualified by bit_valid
//   byte_out     payload byte at the FIFO head (MSB = first received bit)
//   byte_valid   FIFO non-empty
//   byte_ready   consumer accepts byte_out when byte_valid & byte_ready
//   locked       frame alignment held
//   frame_start  one-cycle pulse per accepted sync word
//   overflow     sticky: a payload byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module cdr_frame_sync #(
  parameter logic [7:0] SYNC_WORD   = 8'hA7,
  parameter int         FRAME_BYTES = 4,   // 1..15
  parameter int         MISS_LIMIT  = 2    // 1..3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       frame_start,
  output logic       overflow
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);
  localparam logic [2:0] MISS_MAX  = 3'(MISS_LIMIT);

  state_t     state, state_d;
  logic [7:0] sr, sr_d;
  logic [2:0] bcnt, bcnt_d;
  logic [3:0] byte_cnt, byte_cnt_d;
  logic [1:0] miss, miss_d;
  logic       fs_d;
  logic       push;

  // clear outranks a coincident bit strobe.
  logic       accept;
  logic [7:0] assembled;
  logic [2:0] miss_inc;

  assign accept    = bit_valid & ena & ~clear;
  assign assembled = {sr[6:0], bit_in};
  assign miss_inc  = {1'b0, miss} + 3'd1;

  // ---------------------------------------------------------------------------
  // Aligner next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so that no path through the
    // block leaves one unassigned and no latch is inferred.
    state_d    = state;
    sr_d       = sr;
    bcnt_d     = bcnt;
    byte_cnt_d = byte_cnt;
    miss_d     = miss;
    fs_d       = 1'b0;
    push       = 1'b0;

    if (accept) begin
      sr_d = assembled;
      unique case (state)
        HUNT: begin
          // The window is tested on every bit, so alignment can land on any
          // bit position.
          if (assembled == SYNC_WORD) begin
            state_d    = PAYLOAD;
            bcnt_d     = 3'd0;
            byte_cnt_d = 4'd0;
            miss_d     = 2'd0;
            fs_d       = 1'b1;
          end
        end

        PAYLOAD: begin
          if (bcnt == 3'd7) begin
            push   = 1'b1;
            bcnt_d = 3'd0;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt_d = 4'd0;
              state_d    = CHECK;
            end else begin
              byte_cnt_d = byte_cnt + 4'd1;
            end
          end else begin
            bcnt_d = bcnt + 3'd1;
          end
        end

        CHECK: begin
          if (bcnt == 3'd7) begin
            bcnt_d = 3'd0;
            if (assembled == SYNC_WORD) begin
              miss_d  = 2'd0;
              fs_d    = 1'b1;
              state_d = PAYLOAD;
            end else if (miss_inc < MISS_MAX) begin
              // Flywheel: keep the byte alignment and assume this sync byte
              // was corrupted.
              miss_d  = miss_inc[1:0];
              state_d = PAYLOAD;
            end else begin
              miss_d  = 2'd0;
              state_d = HUNT;
            end
          end else begin
            bcnt_d = bcnt + 3'd1;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Aligner registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sr          <= 8'h00;
      bcnt        <= 3'd0;
      byte_cnt    <= 4'd0;
      miss        <= 2'd0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else if (clear) begin
      state       <= HUNT;
      sr          <= 8'h00;
      bcnt        <= 3'd0;
      byte_cnt    <= 4'd0;
      miss        <= 2'd0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      bcnt        <= bcnt_d;
      byte_cnt    <= byte_cnt_d;
      miss        <= miss_d;
      locked      <= (state_d != HUNT);
      frame_start <= fs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FWFT FIFO: the head register drives byte_out directly, and tail
  // holds the second entry. byte_valid is the head-valid flag. full (tail_v)
  // always implies byte_valid.
  // ---------------------------------------------------------------------------
  logic [7:0] tail;
  logic       tail_v;
  logic       pop;

  assign pop = byte_valid & byte_ready;

  // NOTE: both storage entries are reset, because byte_out must come out of
  // reset at a defined 8'h00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= 8'h00;
      tail       <= 8'h00;
      byte_valid <= 1'b0;
      tail_v     <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      byte_valid <= 1'b0;
      tail_v     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case ({tail_v, byte_valid})
        2'b00: begin
          if (push) begin
            byte_out   <= assembled;
            byte_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (push && pop) begin
            byte_out <= assembled;
          end else if (pop) begin
            byte_valid <= 1'b0;
          end else if (push) begin
            tail   <= assembled;
            tail_v <= 1'b1;
          end
        end
        2'b11: begin
          if (push && pop) begin
            byte_out <= tail;
            tail     <= assembled;
          end else if (pop) begin
            byte_out <= tail;
            tail_v   <= 1'b0;
          end else if (push) begin
            // Full with no pop: drop the byte and keep the contents.
            overflow <= 1'b1;
          end
        end
        default: begin
          byte_valid <= 1'b0;
          tail_v     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cdr_frame_sync.md
CDR_FRAME_SYNC -- requirements
Module: cdr_frame_sync

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA7, 8-bit frame sync pattern, MSB received first.
REQ-002 Parameter FRAME_BYTES, default 4, payload bytes per frame between sync words, range 1..15.
REQ-003 Parameter MISS_LIMIT, default 2, consecutive missed sync words before lock drop, range 1..3.
REQ-004 clk  input  1  system clock, ~50 MHz, all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  block enable; when 0, bit_valid is ignored.
REQ-007 clear  input  1  synchronous flush: state, FIFO, overflow.
REQ-008 bit_valid  input  1  one-cycle pulse per recovered bit (CDR sample_en).
REQ-009 bit_in  input  1  recovered bit (CDR bang-bang decision), qualified by bit_valid.
REQ-010 byte_out  output  8  payload byte at FIFO head, MSB = first received bit.
REQ-011 byte_valid  output  1  FIFO non-empty.
REQ-012 byte_ready  input  1  consumer accepts byte_out when byte_valid & byte_ready.
REQ-013 locked  output  1  frame alignment held.
REQ-014 frame_start  output  1  one-cycle pulse per accepted sync word.
REQ-015 overflow  output  1  sticky, payload byte dropped on full FIFO.

Function
REQ-016 Accepted bit = bit_valid & ena & !clear; on each accepted bit sr <= {sr[6:0], bit_in}.
REQ-017 FSM states HUNT, PAYLOAD, CHECK; bit counter bcnt 0..7, byte counter 0..FRAME_BYTES-1, miss counter 0..MISS_LIMIT.
REQ-018 HUNT: every accepted bit, compare {sr[6:0], bit_in} to SYNC_WORD (bit-sliding search); on match -> PAYLOAD, bcnt=0, byte counter=0, miss=0, locked=1, frame_start=1 next cycle.
REQ-019 PAYLOAD: on the 8th accepted bit (bcnt=7) push {sr[6:0], bit_in} into FIFO; after FRAME_BYTES-th byte -> CHECK, bcnt=0.
REQ-020 CHECK: on 8th accepted bit compare assembled byte to SYNC_WORD; sync bytes are never pushed.
REQ-021 CHECK match -> miss=0, frame_start pulse, PAYLOAD.
REQ-022 CHECK mismatch with miss+1 < MISS_LIMIT -> miss+1, no frame_start, PAYLOAD (flywheel, alignment kept, locked stays 1).
REQ-023 CHECK mismatch with miss+1 = MISS_LIMIT -> HUNT, locked=0 same edge, miss=0.
REQ-024 locked = 1 in PAYLOAD and CHECK, 0 in HUNT; registered.
REQ-025 FIFO: 2 entries, first-word-fall-through; byte_valid and byte_out registered; pushed byte visible one clk after the completing bit_valid cycle.
REQ-026 Pop when byte_valid & byte_ready; simultaneous push and pop allowed in any occupancy, including full (count unchanged, order preserved).
REQ-027 Push while full without pop: byte discarded, FIFO contents unchanged, overflow <= 1 until clear or reset; FSM counting unaffected.
REQ-028 byte_out holds value while byte_valid & !byte_ready; byte_out is don't-care when byte_valid=0.
REQ-029 ena=0: FSM, counters and sr frozen; FIFO pops still honoured; outputs not forced low.
REQ-030 clear=1: next edge -> HUNT, counters 0, sr 0, FIFO empty, overflow 0, locked 0, frame_start 0; clear overrides a coincident bit_valid and pop.
REQ-031 bit_valid pulses closer than 1 clk apart are not supported; back-to-back pulses on consecutive cycles are processed one bit each.

Reset
REQ-032 rst_n low asynchronously forces: HUNT, sr=0, all counters 0, FIFO empty, byte_valid=0, byte_out=8'h00, locked=0, frame_start=0, overflow=0.
REQ-033 Reset mid-frame discards partial byte and FIFO contents; after release, bits are processed from the first bit_valid with rst_n high.

Verification
REQ-034 Bits 0,1,0 then A7, 11,22,33,44, A7, 55 (bit_valid every 4 clk, byte_ready=1) -> frame_start after first A7 and second A7, bytes 11,22,33,44,55 out in order, locked=1 from first A7.
REQ-035 Locked, byte_ready=0, 4 payload bytes -> bytes 1-2 held in FIFO, bytes 3-4 dropped, overflow=1; raise ready -> exactly 2 bytes delivered; clear -> overflow=0, locked=0.
REQ-036 Locked, sync slots carry 00 then A7 -> locked stays 1, no frame_start at 00, frame_start at A7; with 00 then 00 -> locked=0 at end of second bad slot, HUNT resumes.
REQ-037 Full FIFO, pop and push on same cycle -> count stays 2, order preserved, overflow stays 0.
REQ-038 ena=0 during 10 bit_valid pulses mid-payload -> no state change; resume ena=1 -> byte completes with correct value.
REQ-039 rst_n asserted mid-payload with 1 byte pending -> byte_valid=0, locked=0 immediately; reacquire on next A7.
